// File: rtl/kbd_scan_fifo_if.sv
// rtl/kbd_scan_fifo_if.sv - Wishbone slave register bus for the keyboard scancode FIFO
//
// Signals:
//   STB    master->slave  strobe, held until ACK is seen
//   WE     master->slave  write enable
//   ADDR   master->slave  word address (0 data, 1 status/ctrl, 2 flush, 3 spare)
//   DAT_I  master->slave  write data
//   DAT_O  slave->master  read data, valid only while ACK=1
//   ACK    slave->master  one-cycle acknowledge
interface kbd_scan_fifo_if;
  logic        STB;
  logic        WE;
  logic [1:0]  ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;

  modport master (
    output STB, WE, ADDR, DAT_I,
    input  DAT_O, ACK
  );

  modport slave (
    input  STB, WE, ADDR, DAT_I,
    output DAT_O, ACK
  );
endinterface

// File: rtl/kbd_scan_fifo.sv
// rtl/kbd_scan_fifo.sv - keyboard scancode FIFO with Wishbone register access and irq
//
// Purpose: buffers scancode bytes from a keyboard receiver in a DEPTH-entry
// circular buffer; a Wishbone master pops bytes, reads status, clears the
// sticky overflow flag and flushes the buffer.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low
//   ready_pulse    one-cycle strobe, Keyboard_Data valid
//   Keyboard_Data  scancode byte
//   bus            Wishbone slave (kbd_scan_fifo_if.slave)
//   irq            registered, 1 while the FIFO holds data
//
// Build option: define KBD_BREAK_FILTER_EN to drop 0xF0 break prefixes and the
// byte following each one before they reach the buffer.
module kbd_scan_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready_pulse,
  input  logic [7:0]          Keyboard_Data,
  kbd_scan_fifo_if.slave      bus,
  output logic                irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_o_q, dat_o_d;
  logic             irq_q, irq_d;

  logic             empty, full;
  logic             access, rd_acc, wr_acc;
  logic             pop, push, drop, flush, clr_ovf;
  logic             push_req;
  logic [7:0]       cnt8;
  logic             dat_i_unused;

  assign dat_i_unused = ^bus.DAT_I[31:1];

  // Status field is 8 bits wide; the count is zero-extended (or truncated for DEPTH=256).
  generate
    if (CNT_W >= 8) begin : g_cnt_trunc
      assign cnt8 = count_q[7:0];
    end else begin : g_cnt_ext
      assign cnt8 = {{(8-CNT_W){1'b0}}, count_q};
    end
  endgenerate

`ifdef KBD_BREAK_FILTER_EN
  typedef enum logic {F_IDLE, F_BRK} flt_e;
  flt_e flt_q, flt_d;
  logic flt_pass;

  always_ff @(posedge clk) begin
    if (!reset) flt_q <= F_IDLE;
    else        flt_q <= flt_d;
  end

  always_comb begin
    flt_d = flt_q;
    if (ready_pulse) begin
      case (flt_q)
        F_IDLE:  if (Keyboard_Data == 8'hF0) flt_d = F_BRK;
        F_BRK:   flt_d = F_IDLE;
        default: flt_d = F_IDLE;
      endcase
    end
  end

  // The break prefix and the key code that follows it never reach the buffer.
  always_comb begin
    flt_pass = (flt_q == F_IDLE) && (Keyboard_Data != 8'hF0);
  end

  assign push_req = ready_pulse & flt_pass;
`else
  assign push_req = ready_pulse;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    // A bus access commits on the edge that raises ACK, so it happens exactly once.
    access  = bus.STB & ~ack_q;
    rd_acc  = access & ~bus.WE;
    wr_acc  = access & bus.WE;
    pop     = rd_acc & (bus.ADDR == 2'd0) & ~empty;
    flush   = wr_acc & (bus.ADDR == 2'd2);
    clr_ovf = wr_acc & (bus.ADDR == 2'd1) & bus.DAT_I[0];
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    push    = push_req & (~full | pop) & ~flush;
    drop    = push_req & full & ~pop & ~flush;

    ack_d    = access;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    irq_d = (count_d != '0);

    dat_o_d = '0;
    if (rd_acc) begin
      case (bus.ADDR)
        2'd0:    if (!empty) dat_o_d = {23'b0, 1'b1, mem[rd_ptr_q]};
        2'd1:    dat_o_d = {21'b0, cnt8, ovf_q, full, empty};
        default: dat_o_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      dat_o_q  <= dat_o_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr_q] <= Keyboard_Data;
  end

  assign bus.ACK   = ack_q;
  assign bus.DAT_O = dat_o_q;
  assign irq       = irq_q;

endmodule
